// File: rtl/packed_mac_pkg.sv
// Shared constants and helpers for the packed multiply-accumulate unit.
// Lane modes, per-mode lane counts and product widths.
package packed_mac_pkg;

  localparam int MAX_LANES = 8;

  localparam logic [1:0] MODE_INT8 = 2'd0;
  localparam logic [1:0] MODE_INT4 = 2'd1;
  localparam logic [1:0] MODE_INT2 = 2'd2;

  function automatic int lanes_of(input logic [1:0] m);
    case (m)
      MODE_INT8: return 2;
      MODE_INT4: return 4;
      default:   return 8;
    endcase
  endfunction

  function automatic int prod_w(input logic [1:0] m);
    case (m)
      MODE_INT8: return 16;
      MODE_INT4: return 8;
      default:   return 4;
    endcase
  endfunction

  // Reserved encoding 3 behaves as int2.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_INT2 : m;
  endfunction

endpackage

// File: rtl/packed_mac_unit_mult.sv
// Registered lane-wise signed multiplier for packed_mac_unit.
// Products are sign-extended to ACC_W; valid/last/mode ride alongside.
module packed_lane_mult
  import packed_mac_pkg::*;
#(
  parameter int PIPE_STAGES = 4,
  parameter int ACC_W       = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [1:0]                     in_mode,
  input  logic [15:0]                    in_x,
  input  logic [7:0]                     in_y,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [1:0]                     out_mode,
  output logic [MAX_LANES*ACC_W-1:0]     out_prod
);

  localparam int PW = MAX_LANES * ACC_W;

  function automatic logic signed [15:0] mul8(
    input logic signed [7:0] a,
    input logic signed [7:0] b
  );
    logic signed [15:0] ea, eb;
    ea = 16'(a);
    eb = 16'(b);
    return ea * eb;
  endfunction

  function automatic logic signed [7:0] mul4(
    input logic signed [3:0] a,
    input logic signed [3:0] b
  );
    logic signed [7:0] ea, eb;
    ea = 8'(a);
    eb = 8'(b);
    return ea * eb;
  endfunction

  function automatic logic signed [3:0] mul2(
    input logic signed [1:0] a,
    input logic signed [1:0] b
  );
    logic signed [3:0] ea, eb;
    ea = 4'(a);
    eb = 4'(b);
    return ea * eb;
  endfunction

  logic [PW-1:0] prod;

  logic [PIPE_STAGES-1:0] v_q;
  logic [PIPE_STAGES-1:0] l_q;
  logic [1:0]             m_q [PIPE_STAGES];
  logic [PW-1:0]          p_q [PIPE_STAGES];

  // Exact per-lane products for the beat's mode; idle lanes stay zero.
  always_comb begin
    prod = '0;
    unique case (1'b1)
      (in_mode == MODE_INT8): begin
        for (int i = 0; i < 2; i++)
          prod[i*ACC_W +: ACC_W] = ACC_W'(mul8(in_x[8*i +: 8], in_y));
      end
      (in_mode == MODE_INT4): begin
        for (int i = 0; i < 4; i++)
          prod[i*ACC_W +: ACC_W] = ACC_W'(mul4(in_x[4*i +: 4], in_y[3:0]));
      end
      default: begin
        for (int i = 0; i < 8; i++)
          prod[i*ACC_W +: ACC_W] = ACC_W'(mul2(in_x[2*i +: 2], in_y[1:0]));
      end
    endcase
  end

  // Fixed-depth, never-stalling product pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        m_q[s] <= '0;
        p_q[s] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      l_q[0] <= in_last;
      m_q[0] <= in_mode;
      p_q[0] <= prod;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        v_q[s] <= v_q[s-1];
        l_q[s] <= l_q[s-1];
        m_q[s] <= m_q[s-1];
        p_q[s] <= p_q[s-1];
      end
    end
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign out_last  = l_q[PIPE_STAGES-1];
  assign out_mode  = m_q[PIPE_STAGES-1];
  assign out_prod  = p_q[PIPE_STAGES-1];

endmodule

// File: rtl/packed_mac_unit.sv
// Packed int8/int4/int2 multiply-accumulate with credited output queue.
// Define PACKED_MAC_SAT_EN for saturating lane adds (flagged in out_err).
module packed_mac_unit
  import packed_mac_pkg::*;
#(
  parameter int PIPE_STAGES = 4,
  parameter int ACC_W       = 20,
  parameter int OUT_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_x,
  input  logic [7:0]             in_y,
  input  logic [1:0]             in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*ACC_W-1:0]     out_acc,
  output logic [1:0]             out_mode,
  output logic                   out_err
);

  localparam int AW = MAX_LANES * ACC_W;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int QW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  function automatic logic [QW-1:0] bump(input logic [QW-1:0] p);
    return (p == QW'(OUT_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  logic          accept, push, pop;
  logic [1:0]    m_norm, eff_mode, grp_mode;
  logic          grp_open, mism;
  logic [CW-1:0] credits, q_cnt;

  logic          p_valid, p_last;
  logic [1:0]    p_mode;
  logic [AW-1:0] p_prod;
  logic [PIPE_STAGES-1:0] mism_q;

  logic [AW-1:0] acc_q, acc_nxt;
  logic          acc_open, acc_err, err_nxt, sat_any;

  logic [AW-1:0] q_acc  [OUT_DEPTH];
  logic [1:0]    q_mode [OUT_DEPTH];
  logic          q_err  [OUT_DEPTH];
  logic [QW-1:0] wr_ptr, rd_ptr;

  assign in_ready = !reset && (credits != '0);
  assign accept   = in_valid && in_ready;
  assign m_norm   = norm_mode(in_mode);
  assign eff_mode = grp_open ? grp_mode : m_norm;
  assign mism     = grp_open && (m_norm != grp_mode);

  // Latch the group mode from its first accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      grp_open <= 1'b0;
      grp_mode <= MODE_INT8;
    end else if (accept) begin
      if (in_last) begin
        grp_open <= 1'b0;
      end else begin
        grp_open <= 1'b1;
        if (!grp_open) grp_mode <= m_norm;
      end
    end
  end

  packed_lane_mult #(
    .PIPE_STAGES(PIPE_STAGES),
    .ACC_W      (ACC_W)
  ) u_mult (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept),
    .in_last  (in_last),
    .in_mode  (eff_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_valid(p_valid),
    .out_last (p_last),
    .out_mode (p_mode),
    .out_prod (p_prod)
  );

  // Mode-mismatch flag travels in step with its beat's product.
  always_ff @(posedge clk) begin
    if (reset) begin
      mism_q <= '0;
    end else begin
      mism_q[0] <= accept && mism;
      for (int s = 1; s < PIPE_STAGES; s++)
        mism_q[s] <= mism_q[s-1];
    end
  end

  // Next accumulator value: load on a group's first beat, add otherwise.
  always_comb begin
    logic [ACC_W-1:0] base, add;
    logic [ACC_W:0]   sum;
    acc_nxt = '0;
    sat_any = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      base = acc_open ? acc_q[i*ACC_W +: ACC_W] : '0;
      add  = p_prod[i*ACC_W +: ACC_W];
      sum  = {base[ACC_W-1], base} + {add[ACC_W-1], add};
`ifdef PACKED_MAC_SAT_EN
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        sat_any = 1'b1;
        acc_nxt[i*ACC_W +: ACC_W] = sum[ACC_W] ?
          {1'b1, {(ACC_W-1){1'b0}}} :
          {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_nxt[i*ACC_W +: ACC_W] = sum[ACC_W-1:0];
      end
`else
      acc_nxt[i*ACC_W +: ACC_W] = sum[ACC_W-1:0];
`endif
    end
    err_nxt = (acc_open && acc_err) || mism_q[PIPE_STAGES-1] || sat_any;
  end

  // Group accumulator; a last beat hands off to the queue and reopens clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_open <= 1'b0;
      acc_err  <= 1'b0;
      acc_q    <= '0;
    end else if (p_valid) begin
      acc_q <= acc_nxt;
      if (p_last) begin
        acc_open <= 1'b0;
        acc_err  <= 1'b0;
      end else begin
        acc_open <= 1'b1;
        acc_err  <= err_nxt;
      end
    end
  end

  assign push = p_valid && p_last;
  assign pop  = out_valid && out_ready;

  // Output FIFO; credits guarantee a free slot on every push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
      for (int e = 0; e < OUT_DEPTH; e++) begin
        q_acc[e]  <= '0;
        q_mode[e] <= '0;
        q_err[e]  <= 1'b0;
      end
    end else begin
      if (push) begin
        q_acc[wr_ptr]  <= acc_nxt;
        q_mode[wr_ptr] <= p_mode;
        q_err[wr_ptr]  <= err_nxt;
        wr_ptr         <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      unique case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Group credits: spent on an accepted last beat, returned on output.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CW'(OUT_DEPTH);
    end else begin
      unique case ({accept && in_last, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign out_valid = (q_cnt != '0);
  assign out_acc   = out_valid ? q_acc[rd_ptr]  : '0;
  assign out_mode  = out_valid ? q_mode[rd_ptr] : '0;
  assign out_err   = out_valid ? q_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_packed_mac_unit.sv
// Directed bench for packed_mac_unit (ACC_W=20 main, ACC_W=16 overflow).
// Expected overflow result follows PACKED_MAC_SAT_EN.
module tb_packed_mac_unit;

  localparam int P  = 4;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [15:0]   in_x;
  logic [7:0]    in_y;
  logic [1:0]    in_mode, out_mode;
  logic [8*AW-1:0] out_acc;

  logic          w_in_valid, w_in_ready, w_in_last;
  logic          w_out_valid, w_out_ready, w_out_err;
  logic [15:0]   w_in_x;
  logic [7:0]    w_in_y;
  logic [1:0]    w_in_mode, w_out_mode;
  logic [127:0]  w_out_acc;

  int passed = 0;
  int total  = 0;

  logic [8*AW-1:0] got_acc  [$];
  logic [1:0]      got_mode [$];
  logic            got_err  [$];

  always #5 clk = ~clk;

  packed_mac_unit #(.PIPE_STAGES(P), .ACC_W(AW), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_mode(out_mode), .out_err(out_err)
  );

  packed_mac_unit #(.PIPE_STAGES(P), .ACC_W(16), .OUT_DEPTH(2)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_x(w_in_x), .in_y(w_in_y), .in_mode(w_in_mode), .in_last(w_in_last),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_acc(w_out_acc), .out_mode(w_out_mode), .out_err(w_out_err)
  );

  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      got_acc.push_back(out_acc);
      got_mode.push_back(out_mode);
      got_err.push_back(out_err);
    end

  function automatic logic [8*AW-1:0] pk(input int v[8]);
    logic [8*AW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*AW +: AW] = AW'(v[i]);
    return r;
  endfunction

  task automatic flush();
    got_acc.delete();
    got_mode.delete();
    got_err.delete();
  endtask

  task automatic pop_res(output logic [8*AW-1:0] a, output logic [1:0] m,
                         output logic e);
    if (got_acc.size() > 0) begin
      a = got_acc.pop_front();
      m = got_mode.pop_front();
      e = got_err.pop_front();
    end else begin
      a = 'x;
      m = 'x;
      e = 1'bx;
    end
  endtask

  task automatic send_beat(input logic [15:0] x, input logic [7:0] y,
                           input logic [1:0] m, input logic l);
    int w;
    w = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_mode = m; in_last = l;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_beat timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int w;
    w = 0;
    while (got_acc.size() < n && w < 80) begin
      @(negedge clk);
      w++;
    end
    if (got_acc.size() < n) begin
      total++;
      $display("FAIL wait_results got %0d required %0d", got_acc.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_mode = '0;
    w_in_valid = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b1;
    w_in_x = '0; w_in_y = '0; w_in_mode = '0;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b req=0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b req=0", out_valid); else passed++;
    total++; if (out_acc !== '0) $display("FAIL rst_out_acc got=%h req=0", out_acc); else passed++;
    total++; if (out_mode !== 2'd0) $display("FAIL rst_out_mode got=%0d req=0", out_mode); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL rst_out_err got=%b req=0", out_err); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after got=%b req=1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_int8();
    int lat;
    int e[8];
    logic [8*AW-1:0] a;
    logic [1:0] m;
    logic r;
    flush();
    send_beat(16'h807F, 8'h81, 2'd0, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    total++; if (lat != P + 1) $display("FAIL int8_latency got=%0d req=%0d", lat, P + 1); else passed++;
    wait_results(1);
    pop_res(a, m, r);
    e = '{-16129, 16256, 0, 0, 0, 0, 0, 0};
    total++; if (a !== pk(e)) $display("FAIL int8_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (m !== 2'd0) $display("FAIL int8_mode got=%0d req=0", m); else passed++;
    total++; if (r !== 1'b0) $display("FAIL int8_err got=%b req=0", r); else passed++;
  endtask

  task automatic test_int4();
    int e[8];
    logic [8*AW-1:0] a;
    logic [1:0] m;
    logic r;
    flush();
    send_beat(16'hF17F, 8'hA7, 2'd1, 1'b0);
    send_beat(16'hF17F, 8'hA7, 2'd1, 1'b0);
    send_beat(16'hF17F, 8'hA7, 2'd1, 1'b1);
    wait_results(1);
    repeat (10) @(negedge clk);
    total++; if (got_acc.size() != 1) $display("FAIL int4_count got=%0d req=1", got_acc.size()); else passed++;
    @(posedge clk); #1;
    pop_res(a, m, r);
    e = '{-21, 147, 21, -21, 0, 0, 0, 0};
    total++; if (a !== pk(e)) $display("FAIL int4_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (m !== 2'd1) $display("FAIL int4_mode got=%0d req=1", m); else passed++;
    total++; if (r !== 1'b0) $display("FAIL int4_err got=%b req=0", r); else passed++;
  endtask

  task automatic test_int2();
    int e[8];
    logic [8*AW-1:0] a;
    logic [1:0] m;
    logic r;
    flush();
    send_beat(16'hAAAA, 8'h02, 2'd2, 1'b1);
    send_beat(16'hAAAA, 8'hFC, 2'd2, 1'b1);
    send_beat(16'h5555, 8'h03, 2'd3, 1'b1);
    wait_results(3);
    pop_res(a, m, r);
    e = '{4, 4, 4, 4, 4, 4, 4, 4};
    total++; if (a !== pk(e)) $display("FAIL int2_neg_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (m !== 2'd2) $display("FAIL int2_mode got=%0d req=2", m); else passed++;
    pop_res(a, m, r);
    total++; if (a !== '0) $display("FAIL int2_zero_acc got=%h req=0", a); else passed++;
    pop_res(a, m, r);
    e = '{-1, -1, -1, -1, -1, -1, -1, -1};
    total++; if (a !== pk(e)) $display("FAIL mode3_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (m !== 2'd2) $display("FAIL mode3_mode got=%0d req=2", m); else passed++;
  endtask

  task automatic test_backpressure();
    int e[8];
    logic [8*AW-1:0] a, hold;
    logic [1:0] m;
    logic r;
    flush();
    out_ready = 1'b0;
    send_beat(16'h0001, 8'h01, 2'd0, 1'b1);
    send_beat(16'h0002, 8'h01, 2'd0, 1'b1);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_credit_stall got=%b req=0", in_ready); else passed++;
    repeat (8) @(negedge clk);
    e = '{1, 0, 0, 0, 0, 0, 0, 0};
    total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b req=1", out_valid); else passed++;
    total++; if (out_acc !== pk(e)) $display("FAIL bp_head got=%h req=%h", out_acc, pk(e)); else passed++;
    hold = out_acc;
    @(negedge clk);
    total++; if (out_acc !== pk(e) || out_acc !== hold) $display("FAIL bp_hold got=%h req=%h", out_acc, pk(e)); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_before got=%b req=0", in_ready); else passed++;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after got=%b req=1", in_ready); else passed++;
    wait_results(2);
    pop_res(a, m, r);
    total++; if (a !== pk(e)) $display("FAIL bp_first got=%h req=%h", a, pk(e)); else passed++;
    pop_res(a, m, r);
    e = '{2, 0, 0, 0, 0, 0, 0, 0};
    total++; if (a !== pk(e)) $display("FAIL bp_second got=%h req=%h", a, pk(e)); else passed++;
  endtask

  task automatic test_mismatch();
    int e[8];
    logic [8*AW-1:0] a;
    logic [1:0] m;
    logic r;
    flush();
    send_beat(16'h0203, 8'h02, 2'd0, 1'b0);
    send_beat(16'h0101, 8'h03, 2'd1, 1'b1);
    send_beat(16'h1111, 8'h01, 2'd1, 1'b1);
    wait_results(2);
    pop_res(a, m, r);
    e = '{9, 7, 0, 0, 0, 0, 0, 0};
    total++; if (a !== pk(e)) $display("FAIL mism_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (m !== 2'd0) $display("FAIL mism_mode got=%0d req=0", m); else passed++;
    total++; if (r !== 1'b1) $display("FAIL mism_err got=%b req=1", r); else passed++;
    pop_res(a, m, r);
    e = '{1, 1, 1, 1, 0, 0, 0, 0};
    total++; if (a !== pk(e)) $display("FAIL next_acc got=%h req=%h", a, pk(e)); else passed++;
    total++; if (r !== 1'b0) $display("FAIL next_err got=%b req=0", r); else passed++;
  endtask

  task automatic test_back_to_back();
    int e[8];
    logic [8*AW-1:0] a;
    logic [1:0] m;
    logic r;
    flush();
    for (int k = 1; k <= 6; k++)
      send_beat(16'(k), 8'h03, 2'd0, 1'b1);
    wait_results(6);
    for (int k = 1; k <= 6; k++) begin
      pop_res(a, m, r);
      e = '{3 * k, 0, 0, 0, 0, 0, 0, 0};
      total++; if (a !== pk(e)) $display("FAIL b2b_%0d got=%h req=%h", k, a, pk(e)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    out_ready = 1'b1;
    send_beat(16'h0005, 8'h01, 2'd0, 1'b1);
    send_beat(16'h0006, 8'h01, 2'd0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush();
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL rstmid_out_valid got=1 req=0"); else passed++;
    total++; if (got_acc.size() != 0) $display("FAIL rstmid_results got=%0d req=0", got_acc.size()); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got=%b req=1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int w;
    logic [15:0] exp_l0;
    logic exp_err;
`ifdef PACKED_MAC_SAT_EN
    exp_l0 = 16'd32767;
    exp_err = 1'b1;
`else
    exp_l0 = 16'd256;
    exp_err = 1'b0;
`endif
    for (int k = 0; k < 256; k++) begin
      w_in_valid = 1'b1; w_in_x = 16'h007F; w_in_y = 8'h7F;
      w_in_mode = 2'd0; w_in_last = (k == 255);
      w = 0;
      @(negedge clk);
      while (!w_in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      @(posedge clk); #1;
    end
    w_in_valid = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!w_out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++; if (w_out_valid !== 1'b1) $display("FAIL ovf_valid got=%b req=1", w_out_valid); else passed++;
    total++; if (w_out_acc[15:0] !== exp_l0) $display("FAIL ovf_lane0 got=%0d req=%0d", w_out_acc[15:0], exp_l0); else passed++;
    total++; if (w_out_acc[127:16] !== '0) $display("FAIL ovf_upper got=%h req=0", w_out_acc[127:16]); else passed++;
    total++; if (w_out_err !== exp_err) $display("FAIL ovf_err got=%b req=%b", w_out_err, exp_err); else passed++;
    @(posedge clk); #1;
    w_out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_int8();
    test_int4();
    test_int2();
    test_backpressure();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
